// File: rtl/gcd_job_dispatch.sv
// GCD job dispatcher: operand FIFO -> one-at-a-time GCD core -> result FIFO.
// Ports: in_* operand push, core_* core handshake, out_* result pop, busy/jobs_done/timeout_err status.
module gcd_job_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        core_load,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [15:0] jobs_done,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [AW:0] PONE = (AW+1)'(1);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t r_state;
  logic [CW-1:0] r_wcnt;

  // operand FIFO
  logic [63:0] r_op_mem [DEPTH];
  logic [AW:0] r_op_wp;
  logic [AW:0] r_op_rp;
  logic        w_op_empty;
  logic        w_op_full;
  logic        w_op_push;
  logic [63:0] w_op_head;

  // result FIFO
  logic [31:0] r_res_mem [DEPTH];
  logic [AW:0] r_res_wp;
  logic [AW:0] r_res_rp;
  logic        w_res_empty;
  logic        w_res_full;
  logic        w_res_pop;
  logic        w_res_free;
  logic        w_res_push;
  logic [31:0] w_res_wdata;

  logic w_issue;
  logic w_done_push;
  logic w_to_push;

  assign w_op_empty = (r_op_wp == r_op_rp);
  assign w_op_full  = (r_op_wp[AW] != r_op_rp[AW]) &&
                      (r_op_wp[AW-1:0] == r_op_rp[AW-1:0]);
  assign w_op_push  = in_valid && !w_op_full;
  assign w_op_head  = r_op_mem[r_op_rp[AW-1:0]];
  assign in_ready   = !w_op_full;

  assign w_res_empty = (r_res_wp == r_res_rp);
  assign w_res_full  = (r_res_wp[AW] != r_res_rp[AW]) &&
                       (r_res_wp[AW-1:0] == r_res_rp[AW-1:0]);
  assign w_res_pop   = !w_res_empty && out_ready;
  // a result leaving this cycle frees the slot the next job will need
  assign w_res_free  = !w_res_full || w_res_pop;
  assign out_valid   = !w_res_empty;
  assign out_data    = r_res_mem[r_res_rp[AW-1:0]];

  assign w_issue     = (r_state == S_IDLE) && !w_op_empty && w_res_free;
  assign w_done_push = (r_state == S_WAIT) && core_done;
  // a real completion on the terminal count beats the timeout
  assign w_to_push   = (r_state == S_WAIT) && !core_done && (r_wcnt == TERM);
  assign w_res_push  = w_done_push || w_to_push;
  assign w_res_wdata = w_done_push ? core_result : 32'hFFFF_FFFF;

  always_ff @(posedge clk) begin
    if (w_op_push) begin
      r_op_mem[r_op_wp[AW-1:0]] <= {in_a, in_b};
    end
    if (w_res_push) begin
      r_res_mem[r_res_wp[AW-1:0]] <= w_res_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_wp  <= '0;
      r_op_rp  <= '0;
      r_res_wp <= '0;
      r_res_rp <= '0;
    end else begin
      if (w_op_push)  r_op_wp  <= r_op_wp + PONE;
      if (w_issue)    r_op_rp  <= r_op_rp + PONE;
      if (w_res_push) r_res_wp <= r_res_wp + PONE;
      if (w_res_pop)  r_res_rp <= r_res_rp + PONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      core_load   <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      busy        <= 1'b0;
      jobs_done   <= '0;
      timeout_err <= 1'b0;
    end else begin
      core_load <= 1'b0;
      if (w_to_push) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      if (w_res_push) begin
        jobs_done <= jobs_done + 16'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state   <= S_WAIT;
            busy      <= 1'b1;
            core_a    <= w_op_head[63:32];
            core_b    <= w_op_head[31:0];
            core_load <= 1'b1;
            r_wcnt    <= '0;
          end
        end
        S_WAIT: begin
          if (w_res_push) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt + CONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_dispatch.sv
// Scoreboard bench for gcd_job_dispatch with a behavioural GCD core.
// Directed vectors; expected results queued at push, checked by a monitor.
module tb_gcd_job_dispatch;

  localparam int TO = 32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        core_load;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_done;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [15:0] jobs_done;
  logic        timeout_err;
  logic        err_clr;

  int total = 0;
  int bad   = 0;
  int loads = 0;
  int base;
  int core_dly = 5;
  logic prev_load = 1'b0;
  logic [31:0] mdl_g;
  logic [31:0] expq [$];

  gcd_job_dispatch #(
    .DEPTH(4),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .core_load(core_load),
    .core_a(core_a),
    .core_b(core_b),
    .core_done(core_done),
    .core_result(core_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .jobs_done(jobs_done),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait: in_ready stuck 0, want 1 @%0t", $time);
    end else begin
      expq.push_back(exp);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (expq.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, want 0", expq.size());
    end
  endtask

  // behavioural core: answers core_dly cycles after the load cycle
  initial begin
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_load && core_dly >= 0) begin
        mdl_g = gcd(core_a, core_b);
        repeat (core_dly) @(negedge clk);
        core_done = 1'b1;
        core_result = mdl_g;
        @(negedge clk);
        core_done = 1'b0;
        core_result = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (core_load) begin
      chk("load_spacing", {31'd0, prev_load}, 32'd0);
      loads++;
    end
    prev_load = core_load;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result: got %0h want none", out_data);
      end else begin
        chk("result", out_data, expq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load", {31'd0, core_load}, 32'd0);
    chk("rst_core_a", core_a, 32'd0);
    chk("rst_core_b", core_b, 32'd0);
    chk("rst_jobs", {16'd0, jobs_done}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single job: issue one cycle after the push
    out_ready = 1'b1;
    core_dly = 5;
    push(48, 18, 6);
    chk("t1_no_load_yet", {31'd0, core_load}, 32'd0);
    tick();
    chk("t1_load", {31'd0, core_load}, 32'd1);
    chk("t1_core_a", core_a, 32'd48);
    chk("t1_core_b", core_b, 32'd18);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_load_low", {31'd0, core_load}, 32'd0);
    chk("t1_hold_a", core_a, 32'd48);
    drain(50);
    chk("t1_jobs", {16'd0, jobs_done}, 32'd1);

    // stalled core: 1 in flight + 4 queued fills the operand FIFO
    core_dly = 20;
    push(12, 8, 4);
    push(35, 21, 7);
    push(100, 75, 25);
    push(17, 5, 1);
    push(81, 27, 27);
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    drain(400);
    chk("t2_jobs", {16'd0, jobs_done}, 32'd6);

    // blocked consumer: issue stops once result FIFO is full
    out_ready = 1'b0;
    core_dly = 3;
    base = loads;
    push(9, 6, 3);
    push(14, 21, 7);
    push(60, 48, 12);
    push(13, 13, 13);
    push(27, 18, 9);
    repeat (40) tick();
    chk("t3_loads", loads, base + 4);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_jobs", {16'd0, jobs_done}, 32'd10);
    out_ready = 1'b1;
    tick();
    chk("t3_issue_on_pop", {31'd0, core_load}, 32'd1);
    drain(100);
    chk("t3_loads_end", loads, base + 5);
    chk("t3_jobs_end", {16'd0, jobs_done}, 32'd11);

    // dead core: timeout pushes all-ones and sets the sticky flag
    core_dly = -1;
    push(7, 3, 32'hFFFF_FFFF);
    repeat (TO) tick();
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    chk("t4_no_err_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_err", {31'd0, timeout_err}, 32'd1);
    drain(10);
    chk("t4_jobs", {16'd0, jobs_done}, 32'd12);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", {31'd0, timeout_err}, 32'd0);

    // timeout beats a clear in the same cycle
    err_clr = 1'b1;
    push(9, 9, 32'hFFFF_FFFF);
    repeat (TO + 1) tick();
    chk("t4_err_wins", {31'd0, timeout_err}, 32'd1);
    tick();
    chk("t4_clr2", {31'd0, timeout_err}, 32'd0);
    err_clr = 1'b0;
    drain(10);
    chk("t4_jobs2", {16'd0, jobs_done}, 32'd13);

    // completion on the terminal cycle wins over timeout
    core_dly = TO - 1;
    push(40, 24, 8);
    repeat (TO + 1) tick();
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_no_err", {31'd0, timeout_err}, 32'd0);
    drain(10);
    chk("t5_jobs", {16'd0, jobs_done}, 32'd14);

    // reset mid-job discards everything; stray done ignored
    core_dly = 20;
    out_ready = 1'b0;
    push(12, 18, 6);
    push(20, 30, 10);
    push(21, 14, 7);
    repeat (5) tick();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    expq.delete();
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    chk("t6_load", {31'd0, core_load}, 32'd0);
    chk("t6_core_a", core_a, 32'd0);
    chk("t6_core_b", core_b, 32'd0);
    chk("t6_jobs", {16'd0, jobs_done}, 32'd0);
    chk("t6_terr", {31'd0, timeout_err}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (30) tick();
    chk("t6_no_push", {31'd0, out_valid}, 32'd0);
    chk("t6_jobs_after", {16'd0, jobs_done}, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    core_dly = 2;
    push(6, 4, 2);
    drain(30);
    chk("t6_jobs_final", {16'd0, jobs_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
